// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: requester ownership, FSM states and
// default bus widths.
package sram_port_arbiter_pkg;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 8;
  localparam int MAX_BURST_DEFAULT = 4;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the core and the program loader with
// per-beat round-robin and a bounded locked-burst mode for the loader.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int addr_size = ADDR_SIZE,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [addr_size-1:0] cpu_addr,
  input  logic [word_size-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [word_size-1:0] cpu_rdata,
  input  logic                 ldr_req,
  input  logic                 ldr_we,
  input  logic [addr_size-1:0] ldr_addr,
  input  logic [word_size-1:0] ldr_wdata,
  input  logic                 ldr_lock,
  output logic                 ldr_gnt,
  output logic                 ldr_rvalid,
  output logic [word_size-1:0] ldr_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  input  logic [word_size-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_e           state, state_nxt;
  owner_e           last_win, last_win_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             tie_to_cpu;

  // On a tie the side that did not win the previous beat goes next.
  assign tie_to_cpu = (last_win == OWN_LDR);

  assign cpu_gnt = !rst && (state == ST_ARB) && cpu_req && (!ldr_req || tie_to_cpu);
  assign ldr_gnt = !rst && ldr_req && ((state == ST_LOCK) || !cpu_req || !tie_to_cpu);

  assign mem_en    = cpu_gnt | ldr_gnt;
  assign mem_we    = cpu_gnt ? cpu_we    : (ldr_gnt ? ldr_we    : 1'b0);
  assign mem_addr  = cpu_gnt ? cpu_addr  : (ldr_gnt ? ldr_addr  : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : (ldr_gnt ? ldr_wdata : '0);

  assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
  assign ldr_rdata = ldr_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ARB;
      last_win  <= OWN_LDR;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last_win  <= last_win_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_win_nxt  = last_win;
    burst_cnt_nxt = burst_cnt;

    if (cpu_gnt) begin
      last_win_nxt = OWN_CPU;
    end else if (ldr_gnt) begin
      last_win_nxt = OWN_LDR;
    end

    case (state)
      ST_ARB: begin
        // A single-beat limit means the opening beat already ends the burst.
        if (ldr_gnt && ldr_lock && (MAX_BURST > 1)) begin
          state_nxt     = ST_LOCK;
          burst_cnt_nxt = CNT_W'(1);
        end
      end
      ST_LOCK: begin
        if (ldr_gnt) begin
          if (!ldr_lock || (burst_cnt == CNT_W'(MAX_BURST - 1))) begin
            state_nxt     = ST_ARB;
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + CNT_W'(1);
          end
        end else if (!ldr_lock) begin
          state_nxt     = ST_ARB;
          burst_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = ST_ARB;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // The rvalid flags double as the owner tag for the returning read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt & !cpu_we;
      ldr_rvalid <= ldr_gnt & !ldr_we;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a vector table for single-beat traffic
// plus hand-written sequences for locked bursts and reset corner cases.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
  logic [7:0]  ldr_addr;
  logic [15:0] ldr_wdata, ldr_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] mem [256];

  int cmp_count  = 0;
  int fail_count = 0;

  typedef struct {
    logic        cr, cw;
    logic [7:0]  ca;
    logic [15:0] cd;
    logic        lr, lw, lk;
    logic [7:0]  la;
    logic [15:0] ld;
    logic        e_cg, e_lg, e_en, e_we;
    logic [7:0]  e_ma;
    logic [15:0] e_md;
    logic        e_cv;
    logic [15:0] e_crd;
    logic        e_lv;
    logic [15:0] e_lrd;
  } vec_t;

  vec_t vecs[13];

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  function automatic vec_t mk(
    input logic cr, cw, input logic [7:0] ca, input logic [15:0] cd,
    input logic lr, lw, lk, input logic [7:0] la, input logic [15:0] ld,
    input logic gc, gl, en, we, input logic [7:0] ma, input logic [15:0] md,
    input logic cv, input logic [15:0] crd, input logic lv, input logic [15:0] lrd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.lr = lr; v.lw = lw; v.lk = lk; v.la = la; v.ld = ld;
    v.e_cg = gc; v.e_lg = gl; v.e_en = en; v.e_we = we; v.e_ma = ma; v.e_md = md;
    v.e_cv = cv; v.e_crd = crd; v.e_lv = lv; v.e_lrd = lrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_lock = 0; ldr_addr = 0; ldr_wdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one time unit after a rising edge with reset released.
  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    ldr_req = v.lr; ldr_we = v.lw; ldr_lock = v.lk; ldr_addr = v.la; ldr_wdata = v.ld;
  endtask

  task automatic check_output(input int i, input vec_t v);
    chk($sformatf("v%0d cpu_gnt", i), 16'(cpu_gnt), 16'(v.e_cg));
    chk($sformatf("v%0d ldr_gnt", i), 16'(ldr_gnt), 16'(v.e_lg));
    chk($sformatf("v%0d mem_en", i), 16'(mem_en), 16'(v.e_en));
    chk($sformatf("v%0d mem_we", i), 16'(mem_we), 16'(v.e_we));
    chk($sformatf("v%0d mem_addr", i), 16'(mem_addr), 16'(v.e_ma));
    chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.e_md);
    chk($sformatf("v%0d cpu_rvalid", i), 16'(cpu_rvalid), 16'(v.e_cv));
    if (v.e_cv) chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, v.e_crd);
    chk($sformatf("v%0d ldr_rvalid", i), 16'(ldr_rvalid), 16'(v.e_lv));
    if (v.e_lv) chk($sformatf("v%0d ldr_rdata", i), ldr_rdata, v.e_lrd);
  endtask

  task automatic gnt_step(input string name, input logic exp_cg, input logic exp_lg);
    #3;
    chk({name, " cpu_gnt"}, 16'(cpu_gnt), 16'(exp_cg));
    chk({name, " ldr_gnt"}, 16'(ldr_gnt), 16'(exp_lg));
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
    mem[8'h01] <= 16'd1458;
    mem[8'h10] <= 16'h1111;
    mem[8'h20] <= 16'h2222;

    //            cr cw ca     cd        lr lw lk la     ld        gc gl en we ma     md        cv crd       lv lrd
    vecs[0]  = mk(1, 0, 8'h10, 16'h0,    1, 0, 0, 8'h20, 16'h0,    1, 0, 1, 0, 8'h10, 16'h0,    0, 16'h0,    0, 16'h0);
    vecs[1]  = mk(1, 0, 8'h10, 16'h0,    1, 0, 0, 8'h20, 16'h0,    0, 1, 1, 0, 8'h20, 16'h0,    1, 16'h1111, 0, 16'h0);
    vecs[2]  = mk(1, 0, 8'h10, 16'h0,    1, 0, 0, 8'h20, 16'h0,    1, 0, 1, 0, 8'h10, 16'h0,    0, 16'h0,    1, 16'h2222);
    vecs[3]  = mk(1, 0, 8'h10, 16'h0,    1, 0, 0, 8'h20, 16'h0,    0, 1, 1, 0, 8'h20, 16'h0,    1, 16'h1111, 0, 16'h0);
    vecs[4]  = mk(0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 16'h0,    0, 0, 0, 0, 8'h00, 16'h0,    0, 16'h0,    1, 16'h2222);
    vecs[5]  = mk(1, 0, 8'h01, 16'h0,    0, 0, 0, 8'h00, 16'h0,    1, 0, 1, 0, 8'h01, 16'h0,    0, 16'h0,    0, 16'h0);
    vecs[6]  = mk(0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 16'h0,    0, 0, 0, 0, 8'h00, 16'h0,    1, 16'd1458, 0, 16'h0);
    vecs[7]  = mk(0, 0, 8'h00, 16'h0,    1, 1, 0, 8'h04, 16'h7000, 0, 1, 1, 1, 8'h04, 16'h7000, 0, 16'h0,    0, 16'h0);
    vecs[8]  = mk(1, 0, 8'h04, 16'h0,    0, 0, 0, 8'h00, 16'h0,    1, 0, 1, 0, 8'h04, 16'h0,    0, 16'h0,    0, 16'h0);
    vecs[9]  = mk(0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 16'h0,    0, 0, 0, 0, 8'h00, 16'h0,    1, 16'h7000, 0, 16'h0);
    vecs[10] = mk(1, 1, 8'h05, 16'hABCD, 1, 0, 0, 8'h20, 16'h0,    0, 1, 1, 0, 8'h20, 16'h0,    0, 16'h0,    0, 16'h0);
    vecs[11] = mk(1, 1, 8'h05, 16'hABCD, 0, 0, 0, 8'h00, 16'h0,    1, 0, 1, 1, 8'h05, 16'hABCD, 0, 16'h0,    1, 16'h2222);
    vecs[12] = mk(0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 16'h0,    0, 0, 0, 0, 8'h00, 16'h0,    0, 16'h0,    0, 16'h0);

    // Reset state, with both sides requesting to show grants are held off.
    set_idle();
    rst = 1'b1;
    cpu_req = 1; ldr_req = 1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst cpu_gnt", 16'(cpu_gnt), 16'h0);
    chk("rst ldr_gnt", 16'(ldr_gnt), 16'h0);
    chk("rst mem_en", 16'(mem_en), 16'h0);
    chk("rst cpu_rvalid", 16'(cpu_rvalid), 16'h0);
    chk("rst ldr_rvalid", 16'(ldr_rvalid), 16'h0);
    chk("rst cpu_rdata", cpu_rdata, 16'h0);
    do_reset();

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i]);
      #3;
      check_output(i, vecs[i]);
      next_cycle();
    end

    $display("[TB] locked burst hitting the beat limit");
    do_reset();
    ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 8'h00; ldr_wdata = 16'h2000;
    gnt_step("burst beat1", 0, 1);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
    ldr_addr = 8'h01; ldr_wdata = 16'd1458;
    gnt_step("burst beat2", 0, 1);
    ldr_addr = 8'h02; ldr_wdata = 16'h8000;
    gnt_step("burst beat3", 0, 1);
    ldr_addr = 8'h03; ldr_wdata = 16'hD000;
    gnt_step("burst beat4", 0, 1);
    ldr_addr = 8'h04; ldr_wdata = 16'h0000;
    gnt_step("burst release", 1, 0);
    cpu_req = 0;
    #3;
    chk("burst cpu_rvalid", 16'(cpu_rvalid), 16'h1);
    chk("burst cpu_rdata", cpu_rdata, 16'd1458);
    gnt_step("burst ldr again", 0, 1);
    set_idle();
    next_cycle();
    chk("burst mem0", mem[0], 16'h2000);
    chk("burst mem1", mem[1], 16'd1458);
    chk("burst mem2", mem[2], 16'h8000);
    chk("burst mem3", mem[3], 16'hD000);

    $display("[TB] lock dropped on beat 2");
    do_reset();
    ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 8'h08; ldr_wdata = 16'h0001;
    gnt_step("early beat1", 0, 1);
    ldr_lock = 0; ldr_addr = 8'h09;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
    gnt_step("early beat2", 0, 1);
    gnt_step("early cpu next", 1, 0);
    cpu_req = 0;
    gnt_step("early ldr alone", 0, 1);
    set_idle();

    $display("[TB] idle inside lock");
    do_reset();
    ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 8'h0A; ldr_wdata = 16'h00AA;
    gnt_step("hold beat1", 0, 1);
    ldr_req = 0; cpu_req = 1; cpu_addr = 8'h0A;
    for (int k = 0; k < 3; k++) gnt_step($sformatf("hold idle%0d", k), 0, 0);
    ldr_lock = 0;
    gnt_step("hold unlock", 0, 0);
    gnt_step("hold cpu after", 1, 0);
    set_idle();

    $display("[TB] reset during a read and during a burst");
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
    gnt_step("rstrd grant", 1, 0);
    cpu_req = 1; ldr_req = 1;
    rst = 1'b1;
    #1;
    chk("rstrd cpu_rvalid", 16'(cpu_rvalid), 16'h0);
    chk("rstrd cpu_rdata", cpu_rdata, 16'h0);
    chk("rstrd cpu_gnt", 16'(cpu_gnt), 16'h0);
    chk("rstrd ldr_gnt", 16'(ldr_gnt), 16'h0);
    next_cycle();
    rst = 1'b0;
    gnt_step("rstrd tie", 1, 0);
    set_idle();
    ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 8'h0C;
    gnt_step("rstlk beat1", 0, 1);
    ldr_req = 0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    cpu_req = 1; cpu_addr = 8'h0C;
    gnt_step("rstlk released", 1, 0);
    set_idle();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
